mb_spi_reg_slave: RTL

SPI responder that terminates the MicroBlaze SPI master's bus on the imager side and converts each framed transfer into a single-cycle register write or read strobe. It sits on one of the master's slave-select lines. All SPI pins are oversampled in the `USER_CLOCK` domain, so no SPI-clocked logic exists. Register-file logic sees a simple address/data strobe interface.

---
 rtl/mb_spi_reg_slave.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mb_spi_reg_slave.sv
// mb_spi_reg_slave: SPI mode-0 responder, oversampled in USER_CLOCK.
// Each framed transfer (R/W bit, address, data; MSB first) becomes a single
// one-cycle register write or read strobe on a simple address/data port.
module mb_spi_reg_slave #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              USER_CLOCK,
  input  logic              EXT_RESET,
  input  logic              SPI_SCLK,
  input  logic              SPI_SS_N,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              SPI_MISO_OE,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [DATA_W-1:0] REG_WDATA,
  output logic              REG_WR,
  output logic              REG_RD,
  input  logic [DATA_W-1:0] REG_RDATA,
  output logic              FRAME_ERR
);

  localparam int CNT_W = $clog2(ADDR_W + DATA_W + 2);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_DONE} state_t;

  // Synchronizer chains; the last stage is the "synced" pin value.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_s, ss_s, mosi_s;

  // Delayed copies and registered edge pulses, all aligned to each other.
  logic sclk_p_q, sclk_p_d, ss_p_q, ss_p_d, mosi_p_q, mosi_p_d;
  logic rise_q, rise_d, fall_q, fall_d, ss_fall_q, ss_fall_d;

  // Frame state.
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] hdr_sr_q, hdr_sr_d;
  logic [DATA_W-2:0] data_sr_q, data_sr_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              rw_q, rw_d;
  logic              load_q, load_d;

  // Registered outputs.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d, rd_q, rd_d, err_q, err_d;
  logic              miso_q, miso_d, oe_q, oe_d;

  logic [ADDR_W:0]   hdr_full;
  logic [DATA_W-1:0] data_full;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Shift pins into the synchronizers and derive edge pulses from the synced
  // value against its one-cycle-delayed copy.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SPI_SS_N};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    sclk_p_d    = sclk_s;
    ss_p_d      = ss_s;
    mosi_p_d    = mosi_s;
    rise_d      = sclk_s & ~sclk_p_q;
    fall_d      = ~sclk_s & sclk_p_q;
    ss_fall_d   = ~ss_s & ss_p_q;
  end

  // Frame sequencing: header shift, data shift, strobes, MISO and abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_sr_d  = hdr_sr_q;
    data_sr_d = data_sr_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    err_d     = 1'b0;
    load_d    = rd_q;
    hdr_full  = {hdr_sr_q, mosi_p_q};
    data_full = {data_sr_q, mosi_p_q};

    // Read data is captured the cycle after the read strobe.
    if (load_q) begin
      tx_d = REG_RDATA;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_q) begin
          state_d = ST_HDR;
          cnt_d   = '0;
        end
      end
      ST_HDR: begin
        if (rise_q) begin
          if (cnt_q == HDR_LAST) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            rw_d    = hdr_full[ADDR_W];
            addr_d  = hdr_full[ADDR_W-1:0];
            rd_d    = hdr_full[ADDR_W];
            tx_d    = '0;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            hdr_sr_d = hdr_full[ADDR_W-1:0];
          end
        end
      end
      ST_DATA: begin
        if (rise_q) begin
          data_sr_d = data_full[DATA_W-2:0];
          if (cnt_q == DATA_LAST) begin
            state_d = ST_DONE;
            if (!rw_q) begin
              wr_d    = 1'b1;
              wdata_d = data_full;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (fall_q && (cnt_q != '0)) begin
          // The fall at k=0 is the tail of the last header bit and must not
          // shift, otherwise data bit 0 would be lost.
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Select released: abandon the frame; mid-frame release is an error.
    if (ss_p_q && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      err_d   = (state_q == ST_HDR) || (state_q == ST_DATA);
    end

    oe_d   = (state_d != ST_IDLE) && !ss_s;
    miso_d = (state_d == ST_DATA) && rw_d && tx_d[DATA_W-1];
  end

  // All state registers; synchronizers clear to 0 so an SS held low through
  // reset does not look like a fresh select.
  always_ff @(posedge USER_CLOCK) begin
    if (EXT_RESET) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_p_q    <= 1'b0;
      ss_p_q      <= 1'b0;
      mosi_p_q    <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      ss_fall_q   <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hdr_sr_q    <= '0;
      data_sr_q   <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      load_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_p_q    <= sclk_p_d;
      ss_p_q      <= ss_p_d;
      mosi_p_q    <= mosi_p_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      ss_fall_q   <= ss_fall_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_sr_q    <= hdr_sr_d;
      data_sr_q   <= data_sr_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      load_q      <= load_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
    end
  end

  assign SPI_MISO    = miso_q;
  assign SPI_MISO_OE = oe_q;
  assign REG_ADDR    = addr_q;
  assign REG_WDATA   = wdata_q;
  assign REG_WR      = wr_q;
  assign REG_RD      = rd_q;
  assign FRAME_ERR   = err_q;

endmodule
